// File: rtl/md_sequencer.sv
// md_sequencer: iterative 32-bit multiply / divide sequencer.
//
// One operation runs at a time. MUL is a 32-step shift-add producing a 64-bit
// product. DIV/REM is a 32-step restoring division. Both work on operand
// magnitudes, and a single FIXUP cycle then applies the sign. Divide-by-zero
// and signed overflow skip the iterative phase entirely.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_op_i                  MUL / DIV / REM
//   req_in_1_signed_i,
//   req_in_2_signed_i         operand signedness
//   req_out_sel_i             LO / HI / REM result word select
//   req_in_1_i, req_in_2_i    operands (multiplicand/dividend, multiplier/divisor)
//   req_tag_i                 destination tag, echoed on the response
//   kill_i                    flush; abandons any operation in flight
//   resp_valid_o/resp_ready_i response handshake
//   resp_result_o, resp_tag_o registered result word and tag

`ifndef MD_OP_WIDTH
`define MD_OP_WIDTH 2
`define MD_OP_MUL 2'd0
`define MD_OP_DIV 2'd1
`define MD_OP_REM 2'd2
`endif

`ifndef MD_OUT_SEL_WIDTH
`define MD_OUT_SEL_WIDTH 2
`define MD_OUT_LO 2'd0
`define MD_OUT_HI 2'd1
`define MD_OUT_REM 2'd2
`endif

module md_sequencer (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [`MD_OP_WIDTH-1:0]      req_op_i,
  input  logic                         req_in_1_signed_i,
  input  logic                         req_in_2_signed_i,
  input  logic [`MD_OUT_SEL_WIDTH-1:0] req_out_sel_i,
  input  logic [31:0]                  req_in_1_i,
  input  logic [31:0]                  req_in_2_i,
  input  logic [5:0]                   req_tag_i,
  input  logic                         kill_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [31:0]                  resp_result_o,
  output logic [5:0]                   resp_tag_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FIXUP   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Magnitude of a possibly-signed operand; unsigned values pass unchanged.
  function automatic logic [31:0] magnitude(input logic [31:0] val, input logic is_signed);
    if (is_signed && val[31]) begin
      return ~val + 32'd1;
    end else begin
      return val;
    end
  endfunction

  // One shift-add step: {hi, lo} holds partial product (hi) and the
  // not-yet-consumed multiplier bits (lo); the pair shifts right by one.
  function automatic logic [63:0] mul_step(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [31:0] mcand);
    logic [32:0] sum;
    if (lo[0]) begin
      sum = {1'b0, hi} + {1'b0, mcand};
    end else begin
      sum = {1'b0, hi};
    end
    return {sum, lo[31:1]};
  endfunction

  // One restoring-division step: hi is the partial remainder, lo shifts the
  // dividend out at the top while quotient bits enter at the bottom. The
  // remainder stays below the divisor, so the difference never needs bit 32.
  function automatic logic [63:0] div_step(input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [31:0] divisor);
    logic [32:0] shifted;
    logic [32:0] diff;
    shifted = {hi, lo[31]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[32]) begin
      return {diff[31:0], lo[30:0], 1'b1};
    end else begin
      return {shifted[31:0], lo[30:0], 1'b0};
    end
  endfunction

  // Final result word selection.
  function automatic logic [31:0] pick_result(input logic [`MD_OP_WIDTH-1:0] op,
                                              input logic [`MD_OUT_SEL_WIDTH-1:0] sel,
                                              input logic [63:0] prod,
                                              input logic [31:0] quot,
                                              input logic [31:0] rem);
    case (op)
      `MD_OP_MUL: return (sel == `MD_OUT_HI) ? prod[63:32] : prod[31:0];
      `MD_OP_DIV: return (sel == `MD_OUT_REM) ? rem : quot;
      `MD_OP_REM: return rem;
      default:    return 32'd0;
    endcase
  endfunction

  state_t                        state_r, next_state_s;
  logic [4:0]                    cnt_r;
  logic [`MD_OP_WIDTH-1:0]       op_r;
  logic [`MD_OUT_SEL_WIDTH-1:0]  sel_r;
  logic [5:0]                    tag_r;
  logic                          neg_res_r, neg_rem_r;
  logic [31:0]                   op_a_r, acc_hi_r, acc_lo_r;
  logic                          resp_valid_r;
  logic [31:0]                   resp_result_r;
  logic [5:0]                    resp_tag_r;

  logic                          accept_s, is_mul_s, div_zero_s, overflow_s, special_s;
  logic                          neg1_s, neg2_s;
  logic [31:0]                   mag1_s, mag2_s;
  logic [63:0]                   product_s;
  logic [31:0]                   quot_s, rem_s, fixup_result_s;

  assign req_ready_o   = (state_r == IDLE) && !reset_i && !kill_i;
  assign accept_s      = req_valid_i && req_ready_o;
  assign resp_valid_o  = resp_valid_r;
  assign resp_result_o = resp_result_r;
  assign resp_tag_o    = resp_tag_r;

  // Request decode: magnitudes, sign flags and short-circuit cases.
  always_comb begin
    is_mul_s   = (req_op_i == `MD_OP_MUL);
    neg1_s     = req_in_1_signed_i && req_in_1_i[31];
    neg2_s     = req_in_2_signed_i && req_in_2_i[31];
    mag1_s     = magnitude(req_in_1_i, req_in_1_signed_i);
    mag2_s     = magnitude(req_in_2_i, req_in_2_signed_i);
    div_zero_s = !is_mul_s && (req_in_2_i == 32'd0);
    overflow_s = !is_mul_s && req_in_1_signed_i && req_in_2_signed_i &&
                 (req_in_1_i == 32'h8000_0000) && (req_in_2_i == 32'hFFFF_FFFF);
    special_s  = div_zero_s || overflow_s;
  end

  // Sign fixup of the magnitude result and result word selection.
  always_comb begin
    product_s = {acc_hi_r, acc_lo_r};
    if (neg_res_r) begin
      product_s = ~product_s + 64'd1;
      quot_s    = ~acc_lo_r + 32'd1;
    end else begin
      quot_s    = acc_lo_r;
    end
    if (neg_rem_r) begin
      rem_s = ~acc_hi_r + 32'd1;
    end else begin
      rem_s = acc_hi_r;
    end
    fixup_result_s = pick_result(op_r, sel_r, product_s, quot_s, rem_s);
  end

  // Next-state logic; kill overrides everything.
  always_comb begin
    next_state_s = state_r;
    if (kill_i) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = accept_s ? (special_s ? FIXUP : COMPUTE) : IDLE;
        COMPUTE: next_state_s = (cnt_r == 5'd31) ? FIXUP : COMPUTE;
        FIXUP:   next_state_s = DONE;
        DONE:    next_state_s = (resp_valid_r && resp_ready_i) ? IDLE : DONE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture, iteration datapath and registered response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r         <= 5'd0;
      op_r          <= `MD_OP_MUL;
      sel_r         <= `MD_OUT_LO;
      tag_r         <= 6'd0;
      neg_res_r     <= 1'b0;
      neg_rem_r     <= 1'b0;
      op_a_r        <= 32'd0;
      acc_hi_r      <= 32'd0;
      acc_lo_r      <= 32'd0;
      resp_valid_r  <= 1'b0;
      resp_result_r <= 32'd0;
      resp_tag_r    <= 6'd0;
    end else begin
      resp_valid_r <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r      <= req_op_i;
            sel_r     <= req_out_sel_i;
            tag_r     <= req_tag_i;
            cnt_r     <= 5'd0;
            // Short-circuit results are already final: no sign fixup.
            neg_res_r <= !special_s && (neg1_s ^ neg2_s);
            neg_rem_r <= !special_s && neg1_s;
            if (div_zero_s) begin
              op_a_r   <= 32'd0;
              acc_hi_r <= req_in_1_i;
              acc_lo_r <= 32'hFFFF_FFFF;
            end else if (overflow_s) begin
              op_a_r   <= 32'd0;
              acc_hi_r <= 32'd0;
              acc_lo_r <= 32'h8000_0000;
            end else if (is_mul_s) begin
              op_a_r   <= mag1_s;
              acc_hi_r <= 32'd0;
              acc_lo_r <= mag2_s;
            end else begin
              op_a_r   <= mag2_s;
              acc_hi_r <= 32'd0;
              acc_lo_r <= mag1_s;
            end
          end
        end
        COMPUTE: begin
          cnt_r <= cnt_r + 5'd1;
          if (op_r == `MD_OP_MUL) begin
            {acc_hi_r, acc_lo_r} <= mul_step(acc_hi_r, acc_lo_r, op_a_r);
          end else begin
            {acc_hi_r, acc_lo_r} <= div_step(acc_hi_r, acc_lo_r, op_a_r);
          end
        end
        FIXUP: begin
          resp_result_r <= fixup_result_s;
          resp_tag_r    <= tag_r;
        end
        DONE: begin
          resp_result_r <= resp_result_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: scoreboard bench for md_sequencer. The stimulus process
// pushes the expected {result, tag, response cycle} on every accepted request;
// a monitor process pops and compares when a response first appears and checks
// that a stalled response stays stable.

`ifndef MD_OP_WIDTH
`define MD_OP_WIDTH 2
`define MD_OP_MUL 2'd0
`define MD_OP_DIV 2'd1
`define MD_OP_REM 2'd2
`endif

`ifndef MD_OUT_SEL_WIDTH
`define MD_OUT_SEL_WIDTH 2
`define MD_OUT_LO 2'd0
`define MD_OUT_HI 2'd1
`define MD_OUT_REM 2'd2
`endif

module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 2'd0;
  logic        req_in_1_signed_i = 1'b0;
  logic        req_in_2_signed_i = 1'b0;
  logic [1:0]  req_out_sel_i = 2'd0;
  logic [31:0] req_in_1_i = 32'd0;
  logic [31:0] req_in_2_i = 32'd0;
  logic [5:0]  req_tag_i = 6'd0;
  logic        kill_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_result_o;
  logic [5:0]  resp_tag_o;

  always #5 clk = ~clk;

  md_sequencer dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i),
    .req_in_1_signed_i(req_in_1_signed_i), .req_in_2_signed_i(req_in_2_signed_i),
    .req_out_sel_i(req_out_sel_i),
    .req_in_1_i(req_in_1_i), .req_in_2_i(req_in_2_i),
    .req_tag_i(req_tag_i), .kill_i(kill_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_tag_o(resp_tag_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic void model(input logic [1:0] op, input logic s1, input logic s2,
                                input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    logic [63:0] ea, eb, p, qv, rv;
    longint la, lb, q, r;
    ea  = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    lat = 34;
    if (op == `MD_OP_MUL) begin
      p   = ea * eb;
      res = (sel == `MD_OUT_HI) ? p[63:32] : p[31:0];
    end else if (b == 32'd0) begin
      lat = 2;
      res = (op == `MD_OP_DIV) ? 32'hFFFF_FFFF : a;
    end else if (s1 && s2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 2;
      res = (op == `MD_OP_DIV) ? 32'h8000_0000 : 32'd0;
    end else begin
      la  = ea;
      lb  = eb;
      q   = la / lb;
      r   = la % lb;
      qv  = q;
      rv  = r;
      res = (op == `MD_OP_DIV) ? qv[31:0] : rv[31:0];
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Offer one request; pushes the expectation at the accepting cycle.
  task automatic issue(input logic [1:0] op, input logic s1, input logic s2, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                       input logic [31:0] exp_res, input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      check("issue_ready_timeout", {63'd0, req_ready_o}, 64'd1);
      return;
    end
    req_op_i = op; req_in_1_signed_i = s1; req_in_2_signed_i = s2; req_out_sel_i = sel;
    req_in_1_i = a; req_in_2_i = b; req_tag_i = tag; req_valid_i = 1'b1;
    exp_q.push_back('{exp_res, tag, cyc + lat});
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!resp_valid_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid_o) check("resp_valid_timeout", {63'd0, resp_valid_o}, 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(resp_valid_o && resp_ready_i) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(resp_valid_o && resp_ready_i)) check("resp_done_timeout", {63'd0, resp_valid_o}, 64'd1);
    @(negedge clk);
  endtask

  task automatic issue_model(input logic [1:0] op, input logic s1, input logic s2, input logic [1:0] sel,
                             input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    logic [31:0] r;
    int lat;
    model(op, s1, s2, sel, a, b, r, lat);
    issue(op, s1, s2, sel, a, b, tag, r, lat);
  endtask

  // Monitor: compare on the first cycle of each response, then check stability.
  initial begin
    logic        prev_valid;
    logic [31:0] prev_res;
    logic [5:0]  prev_tag;
    exp_t        e;
    prev_valid = 1'b0;
    prev_res   = 32'd0;
    prev_tag   = 6'd0;
    forever begin
      @(negedge clk);
      if (resp_valid_o) begin
        check("ready_low_in_done", {63'd0, req_ready_o}, 64'd0);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=%0h required=none (cycle %0d)", resp_result_o, cyc);
          end else begin
            e = exp_q.pop_front();
            check("resp_result", {32'd0, resp_result_o}, {32'd0, e.res});
            check("resp_tag", {58'd0, resp_tag_o}, {58'd0, e.tag});
            check("resp_cycle", 64'(cyc), 64'(e.due));
          end
        end else begin
          check("stall_result_stable", {32'd0, resp_result_o}, {32'd0, prev_res});
          check("stall_tag_stable", {58'd0, resp_tag_o}, {58'd0, prev_tag});
        end
      end
      prev_valid = resp_valid_o;
      prev_res   = resp_result_o;
      prev_tag   = resp_tag_o;
    end
  end

  initial begin
    exp_t dropped;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, req_ready_o}, 64'd0);
    check("rst_valid", {63'd0, resp_valid_o}, 64'd0);
    check("rst_result", {32'd0, resp_result_o}, 64'd0);
    check("rst_tag", {58'd0, resp_tag_o}, 64'd0);
    reset_i = 1'b0;
    #1 check("ready_after_reset", {63'd0, req_ready_o}, 64'd1);

    // Directed vectors.
    issue(`MD_OP_MUL, 1'b1, 1'b1, `MD_OUT_LO, 32'd7, 32'hFFFF_FFFD, 6'd5, 32'hFFFF_FFEB, 34); wait_done();
    issue(`MD_OP_MUL, 1'b1, 1'b1, `MD_OUT_HI, 32'h8000_0000, 32'h8000_0000, 6'd6, 32'h4000_0000, 34); wait_done();
    issue(`MD_OP_MUL, 1'b0, 1'b0, `MD_OUT_HI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 32'hFFFF_FFFE, 34); wait_done();
    issue(`MD_OP_MUL, 1'b1, 1'b0, `MD_OUT_HI, 32'hFFFF_FFFF, 32'd2, 6'd8, 32'hFFFF_FFFF, 34); wait_done();
    issue(`MD_OP_DIV, 1'b1, 1'b1, `MD_OUT_LO, 32'hFFFF_FFF9, 32'd2, 6'd9, 32'hFFFF_FFFD, 34); wait_done();
    issue(`MD_OP_REM, 1'b1, 1'b1, `MD_OUT_REM, 32'hFFFF_FFF9, 32'd2, 6'd10, 32'hFFFF_FFFF, 34); wait_done();
    issue(`MD_OP_DIV, 1'b0, 1'b0, `MD_OUT_LO, 32'd100, 32'd7, 6'd11, 32'd14, 34); wait_done();
    issue(`MD_OP_REM, 1'b0, 1'b0, `MD_OUT_REM, 32'd100, 32'd7, 6'd12, 32'd2, 34); wait_done();
    issue(`MD_OP_DIV, 1'b0, 1'b0, `MD_OUT_LO, 32'd5, 32'd0, 6'd13, 32'hFFFF_FFFF, 2); wait_done();
    issue(`MD_OP_REM, 1'b1, 1'b1, `MD_OUT_REM, 32'd5, 32'd0, 6'd14, 32'd5, 2); wait_done();
    issue(`MD_OP_DIV, 1'b1, 1'b1, `MD_OUT_LO, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 32'h8000_0000, 2); wait_done();
    issue(`MD_OP_REM, 1'b1, 1'b1, `MD_OUT_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16, 32'd0, 2); wait_done();

    // Randomized operations against the model, with random consumer stalls.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [1:0] sel;
      op  = 2'($urandom_range(0, 2));
      sel = (op == `MD_OP_MUL) ? 2'($urandom_range(0, 1)) :
            (op == `MD_OP_REM) ? `MD_OUT_REM : `MD_OUT_LO;
      resp_ready_i = 1'b0;
      issue_model(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel,
                  pick_val(), pick_val(), 6'($urandom));
      wait_valid();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      resp_ready_i = 1'b1;
      wait_done();
    end

    // Kill in cycle 10 of a DIV, then a MUL completes normally.
    issue(`MD_OP_DIV, 1'b0, 1'b0, `MD_OUT_LO, 32'd1000, 32'd3, 6'd20, 32'd333, 34);
    dropped = exp_q.pop_back();
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    #1;
    check("kill_ready", {63'd0, req_ready_o}, 64'd1);
    check("kill_no_valid", {63'd0, resp_valid_o}, 64'd0);
    issue(`MD_OP_MUL, 1'b0, 1'b0, `MD_OUT_LO, 32'd3, 32'd4, 6'd21, 32'd12, 34); wait_done();

    // Request offered with kill is refused.
    @(negedge clk);
    kill_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = `MD_OP_MUL; req_in_1_i = 32'd2; req_in_2_i = 32'd2;
    #1 check("kill_gates_ready", {63'd0, req_ready_o}, 64'd0);
    @(negedge clk);
    kill_i = 1'b0;
    req_valid_i = 1'b0;
    repeat (40) @(negedge clk);

    // Consumer stall in DONE for 5 cycles.
    resp_ready_i = 1'b0;
    issue(`MD_OP_MUL, 1'b0, 1'b0, `MD_OUT_LO, 32'd11, 32'd13, 6'd22, 32'd143, 34);
    wait_valid();
    repeat (5) @(negedge clk);
    resp_ready_i = 1'b1;
    @(negedge clk);
    check("stall_released_valid", {63'd0, resp_valid_o}, 64'd0);
    check("stall_released_ready", {63'd0, req_ready_o}, 64'd1);

    // Kill coincident with resp_ready in DONE drops the response.
    resp_ready_i = 1'b0;
    issue(`MD_OP_DIV, 1'b0, 1'b0, `MD_OUT_LO, 32'd9, 32'd0, 6'd23, 32'hFFFF_FFFF, 2);
    wait_valid();
    kill_i = 1'b1;
    resp_ready_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    #1 check("kill_done_valid", {63'd0, resp_valid_o}, 64'd0);
    repeat (40) @(negedge clk);

    // Reset pulse mid-COMPUTE abandons the operation.
    issue(`MD_OP_MUL, 1'b1, 1'b1, `MD_OUT_LO, 32'd123, 32'd456, 6'd24, 32'd56088, 34);
    dropped = exp_q.pop_back();
    repeat (5) @(negedge clk);
    reset_i = 1'b1;
    #1 check("reset_mid_ready", {63'd0, req_ready_o}, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("reset_mid_ready_after", {63'd0, req_ready_o}, 64'd1);
    check("reset_mid_valid", {63'd0, resp_valid_o}, 64'd0);
    repeat (40) @(negedge clk);
    issue(`MD_OP_MUL, 1'b0, 1'b0, `MD_OUT_LO, 32'd6, 32'd7, 6'd25, 32'd42, 34); wait_done();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
